// File: rtl/input_debouncer_pkg.sv
// Shared types and constants for the input debouncer and its synchronizer.
package input_debouncer_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam int DEFAULT_STABLE_CYCLES = 4;
    localparam int DEFAULT_CNT_W         = 8;
    localparam logic [7:0] GLITCH_MAX    = 8'd255;

endpackage

// File: rtl/input_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reusable for other async pins.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw button/switch input into a clean level (drives hello.A) plus edge pulses.
// Optional rejected-glitch counter is enabled by defining INPUT_DEBOUNCER_GLITCH_CNT_EN.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_in,
    output logic       level_out,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       busy,
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    output logic [7:0] glitch_cnt,
`endif
    output state_t     state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s2;
    logic [CNT_W-1:0] cnt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (s2)
    );

    // cnt holds how many consecutive s2 samples have disagreed with level_out;
    // any agreeing sample throws the whole count away.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= STABLE_LO;
            cnt        <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (s2) begin
                        state <= WAIT_HI;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (!s2) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= STABLE_HI;
                        level_out  <= 1'b1;
                        rise_pulse <= 1'b1;
                        busy       <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!s2) begin
                        state <= WAIT_LO;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (s2) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= STABLE_LO;
                        level_out  <= 1'b0;
                        fall_pulse <= 1'b1;
                        busy       <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    logic reject;

    assign reject = ((state == WAIT_HI) && !s2) || ((state == WAIT_LO) && s2);

    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_cnt <= 8'd0;
        end else if (reject && (glitch_cnt != GLITCH_MAX)) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Randomized and directed bench for input_debouncer against a run-length reference model.
module tb_input_debouncer;
    import input_debouncer_pkg::*;

    localparam int SC = 4;
    localparam int W  = 14;

    logic       clk;
    logic       rst;
    logic       raw_in;
    logic       level_out;
    logic       rise_pulse;
    logic       fall_pulse;
    logic       busy;
    logic [7:0] glitch_cnt;
    state_t     state;

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs per edge: {state, level, rise, fall, busy, glitch}
    logic [W-1:0] exp_q[$];

    input_debouncer #(.STABLE_CYCLES(SC), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy),
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        .glitch_cnt (glitch_cnt),
`endif
        .state      (state)
    );

`ifndef INPUT_DEBOUNCER_GLITCH_CNT_EN
    assign glitch_cnt = 8'd0;
`endif

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The level flips once SC consecutive synchronized samples disagree with it;
    // an agreeing sample after a partial run counts as a rejected glitch.
    logic m_hist[$];
    logic m_level;
    int   m_run;
    int   m_glitch;

    initial begin
        m_hist   = '{1'b0, 1'b0};
        m_level  = 1'b0;
        m_run    = 0;
        m_glitch = 0;
    end

    always @(posedge clk) begin
        logic   x;
        logic   m_rise;
        logic   m_fall;
        logic   m_busy;
        state_t m_state;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_busy = 1'b0;
        if (rst) begin
            m_hist   = '{1'b0, 1'b0};
            m_level  = 1'b0;
            m_run    = 0;
            m_glitch = 0;
        end else begin
            x = m_hist.pop_front();
            m_hist.push_back(raw_in);
            if (x != m_level) begin
                m_run++;
                if (m_run == SC) begin
                    m_level = x;
                    m_rise  = x;
                    m_fall  = !x;
                    m_run   = 0;
                end else begin
                    m_busy = 1'b1;
                end
            end else begin
                if (m_run > 0 && m_glitch < 255) m_glitch++;
                m_run = 0;
            end
        end
        if (m_level) m_state = (m_run > 0) ? WAIT_LO : STABLE_HI;
        else         m_state = (m_run > 0) ? WAIT_HI : STABLE_LO;
        exp_q.push_back({m_state, m_level, m_rise, m_fall, m_busy, 8'(m_glitch)});
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state", 32'(state), 32'(e[13:12]));
            check("level_out", 32'(level_out), 32'(e[11]));
            check("rise_pulse", 32'(rise_pulse), 32'(e[10]));
            check("fall_pulse", 32'(fall_pulse), 32'(e[9]));
            check("busy", 32'(busy), 32'(e[8]));
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
            check("glitch_cnt", 32'(glitch_cnt), 32'(e[7:0]));
`endif
            if (rise_pulse && fall_pulse) check("pulse_exclusive", 32'(1), 32'(0));
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            raw_in = r;
            rst    = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nf;
        int g0;
        rst    = 1'b1;
        raw_in = 1'b1;

        // reset held two edges with raw_in high
        repeat (2) @(negedge clk);
        check("rst_level", 32'(level_out), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_state", 32'(state), 32'(STABLE_LO));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_level", 32'(level_out), 32'(0));
        check("post_rst_busy", 32'(busy), 32'(0));
        drive(1'b1, 10);

        // clean rise with exact latency
        drive(1'b0, 12);
        check("settled_low", 32'(level_out), 32'(0));
        @(negedge clk);
        raw_in = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            check($sformatf("rise_lat_level_%0d", i), 32'(level_out), 32'(i >= 6));
            check($sformatf("rise_lat_pulse_%0d", i), 32'(rise_pulse), 32'(i == 6));
            check($sformatf("rise_lat_busy_%0d", i), 32'(busy), 32'(i >= 3 && i <= 5));
        end
        drive(1'b1, 4);

        // short glitch from low
        drive(1'b0, 12);
        g0 = int'(glitch_cnt);
        drive(1'b1, 2);
        drive(1'b0, 8);
        check("glitch_level", 32'(level_out), 32'(0));
        check("glitch_busy", 32'(busy), 32'(0));
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        check("glitch_cnt_inc", 32'(glitch_cnt), 32'(g0 + 1));
`endif

        // glitch lasting SC-1 samples is still rejected
        drive(1'b1, SC - 1);
        drive(1'b0, 8);
        check("last_sample_glitch_level", 32'(level_out), 32'(0));

        // bouncy fall
        drive(1'b1, 12);
        check("bouncy_start_level", 32'(level_out), 32'(1));
        nf = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            raw_in = (i == 0 || i == 2) ? 1'b1 : 1'b0;
            nf += int'(fall_pulse);
        end
        check("bouncy_fall_pulses", 32'(nf), 32'(1));
        check("bouncy_fall_level", 32'(level_out), 32'(0));

        // reset in the middle of qualification
        drive(1'b0, 10);
        @(negedge clk);
        raw_in = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_wait_state", 32'(state), 32'(WAIT_HI));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_state", 32'(state), 32'(STABLE_LO));
        check("mid_rst_level", 32'(level_out), 32'(0));
        check("mid_rst_rise", 32'(rise_pulse), 32'(0));
        rst = 1'b0;
        drive(1'b1, 10);

        // random bursts with occasional reset
        for (int b = 0; b < 600; b++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                drive(1'(($urandom_range(0, 1))), $urandom_range(1, 2 * SC + 1));
            end
        end

        // long constant input: idle and not busy
        drive(1'b0, 40);
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_state", 32'(state), 32'(STABLE_LO));

        // many rejected glitches to reach saturation
        for (int g = 0; g < 300; g++) begin
            drive(1'b1, 2);
            drive(1'b0, 3);
        end
        drive(1'b0, 4);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        check("glitch_sat", 32'(glitch_cnt), 32'(255));
        for (int g = 0; g < 5; g++) begin
            drive(1'b1, 2);
            drive(1'b0, 3);
        end
        drive(1'b0, 4);
        check("glitch_sat_hold", 32'(glitch_cnt), 32'(255));
`endif
        check("sat_phase_level", 32'(level_out), 32'(0));

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
